// File: rtl/zircon_segled_pkg.sv
// Shared constants, FSM encoding and digit blanking helper for the
// seven-segment display path.
package zircon_segled_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int BIN_W      = 20;
  localparam int BCD_W      = NUM_DIGITS * 4;
  localparam int CNT_W      = 5;
  localparam int MAX_VAL    = 999999;
  localparam logic [3:0] BLANK_CODE = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  // Replace zero digits above the most significant non-zero digit; digit 0 is kept.
  function automatic logic [BCD_W-1:0] blank_leading(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    logic             lead;
    res  = bcd;
    lead = 1'b1;
    for (int unsigned i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (lead && (bcd[i*4 +: 4] == 4'd0)) begin
        res[i*4 +: 4] = BLANK_CODE;
      end else begin
        lead = 1'b0;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/zircon_bcd_add3.sv
// Double-dabble correction cell: nibbles of 5 or more get +3.
module zircon_bcd_add3 (
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);

  always_comb begin
    o_nib = i_nib;
    if (i_nib >= 4'd5) begin
      o_nib = i_nib + 4'd3;
    end
  end

endmodule

// File: rtl/zircon_segled_bin2bcd.sv
// Sequential 20-bit binary to six-digit BCD converter (one bit per clock)
// with registered, optionally leading-zero-blanked digit outputs.
module zircon_segled_bin2bcd
  import zircon_segled_pkg::*;
#(
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic             CLK_50M,
  input  logic             RST_N,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [3:0]       seg_data1,
  output logic [3:0]       seg_data2,
  output logic [3:0]       seg_data3,
  output logic [3:0]       seg_data4,
  output logic [3:0]       seg_data5,
  output logic [3:0]       seg_data6
);

  state_t                 r_state;
  state_t                 w_next;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_ovf;
  logic                   r_ovf_flag;
  logic [BIN_W-1:0]       r_shift;
  logic [BCD_W-1:0]       r_bcd;
  logic [CNT_W-1:0]       r_cnt;
  logic [BCD_W-1:0]       r_seg;
  logic [BCD_W-1:0]       w_bcd_adj;
  logic [BCD_W+BIN_W-1:0] w_shifted;
  logic [BCD_W-1:0]       w_seg_final;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
    zircon_bcd_add3 u_add3 (
      .i_nib (r_bcd[g*4 +: 4]),
      .o_nib (w_bcd_adj[g*4 +: 4])
    );
  end

  // The accumulator MSB shifted out here can only be set by overflow inputs.
  assign w_shifted = {w_bcd_adj, r_shift} << 1;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next = ST_CONV;
      ST_CONV: if (r_cnt == CNT_W'(BIN_W - 1)) w_next = ST_FIN;
      ST_FIN:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_seg_final = r_bcd;
    if (r_ovf_flag) begin
      w_seg_final = '1;
    end else if (BLANK_LZ) begin
      w_seg_final = blank_leading(r_bcd);
    end
  end

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= ST_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      r_ovf_flag <= 1'b0;
      r_shift    <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_seg      <= '0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != ST_IDLE);
      r_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_shift    <= bin_in;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_ovf_flag <= (bin_in > BIN_W'(MAX_VAL));
          end
        end
        ST_CONV: begin
          {r_bcd, r_shift} <= w_shifted;
          r_cnt            <= r_cnt + CNT_W'(1);
        end
        ST_FIN: begin
          r_seg  <= w_seg_final;
          r_ovf  <= r_ovf_flag;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign ovf       = r_ovf;
  assign seg_data1 = r_seg[3:0];
  assign seg_data2 = r_seg[7:4];
  assign seg_data3 = r_seg[11:8];
  assign seg_data4 = r_seg[15:12];
  assign seg_data5 = r_seg[19:16];
  assign seg_data6 = r_seg[23:20];

endmodule

// File: tb/tb_zircon_segled_bin2bcd.sv
// Self-checking bench for zircon_segled_bin2bcd: a blanking and a
// non-blanking instance share stimulus and are checked against a decimal model.
module tb_zircon_segled_bin2bcd;

  logic        CLK_50M = 1'b0;
  logic        RST_N   = 1'b0;
  logic        start   = 1'b0;
  logic [19:0] bin_in  = '0;

  logic       busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
  logic [3:0] sa1, sa2, sa3, sa4, sa5, sa6;
  logic [3:0] sb1, sb2, sb3, sb4, sb5, sb6;
  logic [23:0] segs_a, segs_b;

  int n_cmp  = 0;
  int n_fail = 0;

  assign segs_a = {sa6, sa5, sa4, sa3, sa2, sa1};
  assign segs_b = {sb6, sb5, sb4, sb3, sb2, sb1};

  always #10 CLK_50M = ~CLK_50M;

  zircon_segled_bin2bcd #(.BLANK_LZ(1'b1)) u_dut_blank (
    .CLK_50M(CLK_50M), .RST_N(RST_N), .start(start), .bin_in(bin_in),
    .busy(busy_a), .done(done_a), .ovf(ovf_a),
    .seg_data1(sa1), .seg_data2(sa2), .seg_data3(sa3),
    .seg_data4(sa4), .seg_data5(sa5), .seg_data6(sa6)
  );

  zircon_segled_bin2bcd #(.BLANK_LZ(1'b0)) u_dut_plain (
    .CLK_50M(CLK_50M), .RST_N(RST_N), .start(start), .bin_in(bin_in),
    .busy(busy_b), .done(done_b), .ovf(ovf_b),
    .seg_data1(sb1), .seg_data2(sb2), .seg_data3(sb3),
    .seg_data4(sb4), .seg_data5(sb5), .seg_data6(sb6)
  );

  // Decimal reference: digits by division, blanking by scanning from the top digit.
  function automatic logic [23:0] ref_digits(input int unsigned v, input bit blank);
    logic [23:0] r;
    int unsigned t;
    r = '0;
    if (v > 999999) return 24'hFFFFFF;
    t = v;
    for (int d = 0; d < 6; d++) begin
      r[d*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    if (blank) begin
      for (int d = 5; d >= 1; d--) begin
        if (r[d*4 +: 4] != 4'd0) break;
        r[d*4 +: 4] = 4'hF;
      end
    end
    return r;
  endfunction

  // Issues a one-cycle start from IDLE; returns edges to done and busy-cycle count.
  task automatic convert(input logic [19:0] v, output int lat, output int busy_cycles);
    @(negedge CLK_50M);
    bin_in = v;
    start  = 1'b1;
    @(posedge CLK_50M);
    #1;
    start       = 1'b0;
    lat         = 0;
    busy_cycles = busy_a ? 1 : 0;
    while (lat < 40 && !done_a) begin
      @(posedge CLK_50M);
      #1;
      lat++;
      if (busy_a) busy_cycles++;
    end
  endtask

  task automatic test_reset();
    int bad;
    RST_N = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge CLK_50M);
    #1;
    n_cmp++;
    if ({segs_a, segs_b, busy_a, done_a, ovf_a} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: segs=%h/%h busy=%b done=%b ovf=%b, required all zero",
               segs_a, segs_b, busy_a, done_a, ovf_a);
    end
    @(negedge CLK_50M);
    RST_N = 1'b1;
    bad = 0;
    repeat (30) begin
      @(negedge CLK_50M);
      if ({segs_a, segs_b, busy_a, done_a, ovf_a, busy_b, done_b, ovf_b} !== '0) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL reset_hold: %0d cycles with non-zero outputs, required 0", bad);
    end
  endtask

  task automatic test_directed();
    logic [19:0] vals [7];
    int lat, bc;
    vals = '{20'd123456, 20'd999999, 20'd1000000, 20'd7, 20'd42, 20'd0, 20'd100005};
    foreach (vals[i]) begin
      convert(vals[i], lat, bc);
      n_cmp++;
      if (lat !== 21) begin
        n_fail++;
        $display("FAIL dir_latency[%0d]: got %0d, required 21", vals[i], lat);
      end
      n_cmp++;
      if (bc !== 21) begin
        n_fail++;
        $display("FAIL dir_busy_cycles[%0d]: got %0d, required 21", vals[i], bc);
      end
      n_cmp++;
      if (segs_a !== ref_digits(vals[i], 1'b1)) begin
        n_fail++;
        $display("FAIL dir_blank[%0d]: got %h, required %h", vals[i], segs_a, ref_digits(vals[i], 1'b1));
      end
      n_cmp++;
      if (segs_b !== ref_digits(vals[i], 1'b0)) begin
        n_fail++;
        $display("FAIL dir_plain[%0d]: got %h, required %h", vals[i], segs_b, ref_digits(vals[i], 1'b0));
      end
      n_cmp++;
      if ({ovf_a, ovf_b, done_b} !== {vals[i] > 20'd999999, vals[i] > 20'd999999, 1'b1}) begin
        n_fail++;
        $display("FAIL dir_ovf[%0d]: got ovf=%b/%b done_b=%b, required ovf=%b done_b=1",
                 vals[i], ovf_a, ovf_b, done_b, vals[i] > 20'd999999);
      end
      @(posedge CLK_50M);
      #1;
      n_cmp++;
      if ({done_a, busy_a} !== 2'b00) begin
        n_fail++;
        $display("FAIL dir_done_pulse[%0d]: done=%b busy=%b, required 0 0", vals[i], done_a, busy_a);
      end
    end
  endtask

  task automatic test_random();
    int lat, bc;
    logic [19:0] v;
    for (int i = 0; i < 16; i++) begin
      v = (i % 3 == 0) ? 20'($urandom_range(0, 999)) : 20'($urandom_range(0, 20'hFFFFF));
      convert(v, lat, bc);
      n_cmp++;
      if (lat !== 21 || segs_a !== ref_digits(v, 1'b1) || segs_b !== ref_digits(v, 1'b0)
          || ovf_a !== (v > 20'd999999)) begin
        n_fail++;
        $display("FAIL rand[%0d]: lat=%0d segs=%h/%h ovf=%b, required lat=21 segs=%h/%h ovf=%b",
                 v, lat, segs_a, segs_b, ovf_a, ref_digits(v, 1'b1), ref_digits(v, 1'b0),
                 v > 20'd999999);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] vals [4];
    logic [19:0] exp_v;
    int cyc, got, last;
    vals = '{20'($urandom_range(0, 999999)), 20'($urandom_range(0, 999)),
             20'($urandom_range(0, 999999)), 20'($urandom_range(0, 99))};
    @(negedge CLK_50M);
    exp_v  = vals[0];
    bin_in = exp_v;
    start  = 1'b1;
    cyc = 0; got = 0; last = 0;
    while (got < 4 && cyc < 200) begin
      @(posedge CLK_50M);
      #1;
      cyc++;
      if (done_a) begin
        n_cmp++;
        if (segs_a !== ref_digits(exp_v, 1'b1)) begin
          n_fail++;
          $display("FAIL b2b_value[%0d]: got %h, required %h", got, segs_a, ref_digits(exp_v, 1'b1));
        end
        if (got > 0) begin
          n_cmp++;
          if (cyc - last !== 22) begin
            n_fail++;
            $display("FAIL b2b_period[%0d]: got %0d, required 22", got, cyc - last);
          end
        end
        last = cyc;
        got++;
        if (got < 4) begin
          exp_v  = vals[got];
          bin_in = exp_v;
        end
      end
    end
    start = 1'b0;
    n_cmp++;
    if (got !== 4) begin
      n_fail++;
      $display("FAIL b2b_timeout: got %0d done pulses, required 4", got);
    end
    repeat (2) @(posedge CLK_50M);
  endtask

  task automatic test_ignore_start();
    int lat, bad;
    logic [19:0] v1, v2;
    v1 = 20'd271828;
    v2 = 20'd31415;
    @(negedge CLK_50M);
    bin_in = v1;
    start  = 1'b1;
    @(posedge CLK_50M);
    #1;
    start = 1'b0;
    lat = 0;
    repeat (4) begin
      @(posedge CLK_50M);
      #1;
      lat++;
    end
    start  = 1'b1;
    bin_in = v2;
    @(posedge CLK_50M);
    #1;
    lat++;
    start = 1'b0;
    while (lat < 40 && !done_a) begin
      @(posedge CLK_50M);
      #1;
      lat++;
    end
    n_cmp++;
    if (lat !== 21 || segs_a !== ref_digits(v1, 1'b1)) begin
      n_fail++;
      $display("FAIL ignore_busy_start: lat=%0d segs=%h, required lat=21 segs=%h",
               lat, segs_a, ref_digits(v1, 1'b1));
    end
    bad = 0;
    repeat (30) begin
      @(posedge CLK_50M);
      #1;
      if (done_a || busy_a) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL ignore_no_queue: %0d busy/done cycles, required 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bc, bad;
    @(negedge CLK_50M);
    bin_in = 20'd555555;
    start  = 1'b1;
    @(posedge CLK_50M);
    #1;
    start = 1'b0;
    repeat (10) @(posedge CLK_50M);
    #5;
    RST_N = 1'b0;
    #1;
    n_cmp++;
    if ({segs_a, segs_b, busy_a, done_a, ovf_a} !== '0) begin
      n_fail++;
      $display("FAIL midreset_clear: segs=%h/%h busy=%b done=%b ovf=%b, required all zero",
               segs_a, segs_b, busy_a, done_a, ovf_a);
    end
    @(negedge CLK_50M);
    @(negedge CLK_50M);
    RST_N = 1'b1;
    bad = 0;
    repeat (30) begin
      @(posedge CLK_50M);
      #1;
      if (done_a || busy_a) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL midreset_no_done: %0d busy/done cycles, required 0", bad);
    end
    convert(20'd31, lat, bc);
    n_cmp++;
    if (lat !== 21 || segs_a !== 24'hFFFF31 || segs_b !== 24'h000031) begin
      n_fail++;
      $display("FAIL midreset_next: lat=%0d segs=%h/%h, required lat=21 segs=ffff31/000031",
               lat, segs_a, segs_b);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
